// File: rtl/matrix_h_pkg.sv
// Shared definitions for the runtime-loadable 4x4 complex channel matrix H.
// WIDTH  : bits per real/imag component (signed two's complement)
// N      : matrix dimension
// DEPTH  : elements per bank (N*N)
// ADDR_W : flat element index width
package matrix_h_pkg;

  localparam int WIDTH  = 16;
  localparam int N      = 4;
  localparam int DEPTH  = N * N;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic signed [WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } state_t;

endpackage

// File: rtl/matrix_h_bank.sv
// One DEPTH x WIDTH storage bank: synchronous write port plus a registered
// read port. Read-before-write on an address collision.
// Ports:
//   clk, rst_n : clock, async active-low reset (read register only)
//   we         : write enable
//   wr_addr    : write element index
//   wr_data    : write sample
//   rd_addr    : read element index
//   rd_data    : registered read sample, one-cycle latency
module matrix_h_bank
  import matrix_h_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  sample_t           wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output sample_t           rd_data
);

  sample_t mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/matrix_h_writer.sv
// Loader for the 4x4 complex channel matrix H. Accepts a row-major stream of
// complex samples over valid/ready and stores them in real/imag banks, with
// the Matrix_H read interface (row 0 = real, row 1 = imag, one-cycle latency).
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : begin/restart a load, clears the write pointer
//   in_valid/in_ready : input handshake
//   in_real, in_im    : sample for element wr_count
//   wr_count          : elements accepted in the current load (0..DEPTH)
//   full              : all DEPTH elements loaded
//   load_done         : one-cycle pulse after the final beat
//   row, collum       : read bank select and flat element index
//   data_out          : registered read data
module matrix_h_writer
  import matrix_h_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_real,
  input  logic [WIDTH-1:0]  in_im,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              load_done,
  input  logic              row,
  input  logic [ADDR_W-1:0] collum,
  output logic [WIDTH-1:0]  data_out
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t           state, state_n;
  logic [ADDR_W:0]  count_n;
  logic             full_n, done_n;
  logic             accept;
  logic             row_q;
  sample_t          re_q, im_q;

  assign in_ready = (state == LOAD) && !start;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_count  <= '0;
      full      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state     <= state_n;
      wr_count  <= count_n;
      full      <= full_n;
      load_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = wr_count;
    full_n  = full;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          count_n = '0;
        end
      end
      LOAD: begin
        if (start) begin
          count_n = '0;
        end else if (accept) begin
          count_n = wr_count + 1'b1;
          if (wr_count == LAST) begin
            state_n = FULL;
            full_n  = 1'b1;
            done_n  = 1'b1;
          end
        end
      end
      FULL: begin
        if (start) begin
          state_n = LOAD;
          count_n = '0;
          full_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  matrix_h_bank u_real_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept),
    .wr_addr (wr_count[ADDR_W-1:0]),
    .wr_data (sample_t'(in_real)),
    .rd_addr (collum),
    .rd_data (re_q)
  );

  matrix_h_bank u_im_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept),
    .wr_addr (wr_count[ADDR_W-1:0]),
    .wr_data (sample_t'(in_im)),
    .rd_addr (collum),
    .rd_data (im_q)
  );

  // Both banks read every cycle; the bank select is registered alongside
  // them so the mux sits after the read registers and latency stays at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row_q <= 1'b0;
    else        row_q <= row;
  end

  assign data_out = row_q ? im_q : re_q;

endmodule
